// File: rtl/tone_detector.sv
// Square-wave note detector: measures rising-edge period of tone_in in clk cycles,
// matches it against the C4..C5 note table and strobes stable notes.
module tone_detector #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TOL_SHIFT   = 5,
  parameter int unsigned MATCH_COUNT = 2,
  parameter int unsigned MIN_PERIOD  = 16,
  parameter int unsigned TIMEOUT     = CLK_HZ / 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic             note_hit,
  output logic [CNT_W-1:0] period,
  output logic             silence
);

  localparam int unsigned STREAK_W = $clog2(MATCH_COUNT + 1);
  localparam int unsigned NoteHz [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
  localparam logic [CNT_W-1:0]    TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]    MinP     = CNT_W'(MIN_PERIOD);
  localparam logic [STREAK_W-1:0] MatchC   = STREAK_W'(MATCH_COUNT);

  typedef enum logic [1:0] {StIdle, StMeasure, StClassify, StReport} state_e;

  // Elaboration-time note table: period and tolerance per entry.
  logic [CNT_W-1:0] note_p   [8];
  logic [CNT_W-1:0] note_tol [8];
  for (genvar g = 0; g < 8; g++) begin : g_tab
    assign note_p[g]   = CNT_W'(CLK_HZ / NoteHz[g]);
    assign note_tol[g] = note_p[g] >> TOL_SHIFT;
  end

  logic sync1_q, sync2_q, prev_q, rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [2:0] cls_idx_q, cls_idx_d;
  logic found_q, found_d;
  logic [2:0] found_idx_q, found_idx_d;
  logic disc_q, disc_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic note_valid_q, note_valid_d;
  logic [2:0] note_idx_q, note_idx_d;
  logic note_hit_q, note_hit_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic silence_q, silence_d;

  logic [CNT_W-1:0] cur_p, cur_tol, diff;
  logic cur_match, hit_now;
  logic [2:0] idx_now;
  logic [STREAK_W-1:0] streak_inc, streak_new;

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Counter value at a rise equals the spacing to the previous rise.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < TimeoutC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cur_p     = note_p[cls_idx_q];
  assign cur_tol   = note_tol[cls_idx_q];
  assign diff      = (lat_q >= cur_p) ? (lat_q - cur_p) : (cur_p - lat_q);
  assign cur_match = (diff <= cur_tol);

  assign hit_now    = found_q | cur_match;
  assign idx_now    = found_q ? found_idx_q : cls_idx_q;
  assign streak_inc = (streak_q >= MatchC) ? streak_q : streak_q + 1'b1;
  assign streak_new = (idx_now == last_idx_q) ? streak_inc : STREAK_W'(1);

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    cls_idx_d    = cls_idx_q;
    found_d      = found_q;
    found_idx_d  = found_idx_q;
    disc_d       = disc_q;
    streak_d     = streak_q;
    last_idx_d   = last_idx_q;
    note_valid_d = 1'b0;
    note_idx_d   = note_idx_q;
    note_hit_d   = note_hit_q;
    period_d     = period_q;
    silence_d    = silence_q;
    case (state_q)
      StIdle: begin
        if (rise) state_d = StMeasure;
      end
      StMeasure: begin
        if (rise) begin
          if (cnt_q >= MinP) begin
            period_d  = cnt_q;
            silence_d = 1'b0;
            lat_d     = cnt_q;
            cls_idx_d = 3'd0;
            found_d   = 1'b0;
            disc_d    = 1'b0;
            state_d   = StClassify;
          end else begin
            streak_d = '0;
          end
        end else if (cnt_q == TimeoutC) begin
          silence_d  = 1'b1;
          note_hit_d = 1'b0;
          streak_d   = '0;
          state_d    = StIdle;
        end
      end
      StClassify: begin
        cls_idx_d = cls_idx_q + 3'd1;
        if (rise) disc_d = 1'b1;
        if (cur_match && !found_q) begin
          found_d     = 1'b1;
          found_idx_d = cls_idx_q;
        end
        // Report decision is registered on the way into StReport so the strobe is a flop output.
        if (cls_idx_q == 3'd7) begin
          state_d    = StReport;
          note_hit_d = hit_now;
          if (hit_now) begin
            last_idx_d = idx_now;
            if (streak_new >= MatchC) begin
              note_valid_d = 1'b1;
              note_idx_d   = idx_now;
            end
          end
          streak_d = (hit_now && !(disc_q || rise)) ? streak_new : '0;
        end
      end
      StReport: begin
        if (rise) streak_d = '0;
        state_d = StMeasure;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      state_q      <= StIdle;
      lat_q        <= '0;
      cls_idx_q    <= 3'd0;
      found_q      <= 1'b0;
      found_idx_q  <= 3'd0;
      disc_q       <= 1'b0;
      streak_q     <= '0;
      last_idx_q   <= 3'd0;
      note_valid_q <= 1'b0;
      note_idx_q   <= 3'd0;
      note_hit_q   <= 1'b0;
      period_q     <= '0;
      silence_q    <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      lat_q        <= lat_d;
      cls_idx_q    <= cls_idx_d;
      found_q      <= found_d;
      found_idx_q  <= found_idx_d;
      disc_q       <= disc_d;
      streak_q     <= streak_d;
      last_idx_q   <= last_idx_d;
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      note_hit_q   <= note_hit_d;
      period_q     <= period_d;
      silence_q    <= silence_d;
    end
  end

  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;
  assign note_hit   = note_hit_q;
  assign period     = period_q;
  assign silence    = silence_q;

endmodule

// File: tb/tb_tone_detector.sv
// Randomised + directed bench for tone_detector: a note-level reference model predicts
// strobes into a queue that an independent monitor drains.
module tb_tone_detector;

  localparam int CLK_HZ      = 1_000_000;
  localparam int CNT_W       = 24;
  localparam int TOL_SHIFT   = 5;
  localparam int MATCH_COUNT = 2;
  localparam int MIN_PERIOD  = 16;
  localparam int TIMEOUT     = 10_000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tone_in;
  logic             note_valid;
  logic [2:0]       note_idx;
  logic             note_hit;
  logic [CNT_W-1:0] period;
  logic             silence;

  tone_detector #(
    .CLK_HZ     (CLK_HZ),
    .CNT_W      (CNT_W),
    .TOL_SHIFT  (TOL_SHIFT),
    .MATCH_COUNT(MATCH_COUNT),
    .MIN_PERIOD (MIN_PERIOD),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .note_valid(note_valid),
    .note_idx  (note_idx),
    .note_hit  (note_hit),
    .period    (period),
    .silence   (silence)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int per;
  } exp_t;
  exp_t exp_q[$];

  int hz_tab [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  // Reference model state (note-level view of the detector)
  bit m_have_prev;
  int m_prev_t, m_streak, m_last_idx, m_period, m_idx;
  bit m_hit, m_silence;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int classify(input int n);
    for (int i = 0; i < 8; i++) begin
      int p, d;
      p = CLK_HZ / hz_tab[i];
      d = (n > p) ? n - p : p - n;
      if (d <= (p >> TOL_SHIFT)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_have_prev = 0; m_prev_t = 0; m_streak = 0; m_last_idx = 0;
    m_period = 0; m_idx = 0; m_hit = 0; m_silence = 1;
    exp_q.delete();
  endtask

  task automatic model_silence();
    m_have_prev = 0; m_silence = 1; m_hit = 0; m_streak = 0;
  endtask

  task automatic model_rise(input int t);
    int n, idx;
    exp_t e;
    if (!m_have_prev || (t - m_prev_t) > TIMEOUT) begin
      if (m_have_prev) model_silence();
      m_have_prev = 1;
      m_prev_t = t;
      return;
    end
    n = t - m_prev_t;
    m_prev_t = t;
    if (n < MIN_PERIOD) begin
      m_streak = 0;
      return;
    end
    m_period = n;
    m_silence = 0;
    idx = classify(n);
    if (idx < 0) begin
      m_hit = 0;
      m_streak = 0;
    end else begin
      m_hit = 1;
      m_streak = (idx == m_last_idx) ? m_streak + 1 : 1;
      m_last_idx = idx;
      if (m_streak >= MATCH_COUNT) begin
        m_idx = idx;
        e.idx = idx;
        e.per = n;
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a negedge; one rising edge on the pin, then high/low phases.
  task automatic drive_period(input int h, input int l);
    model_rise(cyc);
    tone_in = 1'b1;
    repeat (h) @(negedge clk);
    tone_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, " period"}, period, m_period);
    check({tag, " note_hit"}, note_hit, m_hit);
    check({tag, " silence"}, silence, m_silence);
    check({tag, " note_idx"}, note_idx, m_idx);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " note_valid"}, note_valid, 0);
    check({tag, " note_idx"}, note_idx, 0);
    check({tag, " note_hit"}, note_hit, 0);
    check({tag, " period"}, period, 0);
    check({tag, " silence"}, silence, 1);
  endtask

  // Monitor: every strobe must match the oldest predicted note.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && note_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected strobe: idx %0d period %0d, expected no strobe", note_idx, period);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe idx", note_idx, e.idx);
        check("strobe period", period, e.per);
        check("strobe note_hit", note_hit, 1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_last;
    rst_n = 1'b0;
    tone_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // A4 stream
    for (int i = 0; i < 3; i++) begin
      drive_period(1136, 1136);
      check_status("a4");
    end

    // Tolerance edge: 2330 in, 2400 out
    drive_period(1165, 1165);
    check_status("tol_in_a");
    drive_period(1200, 1200);
    check_status("tol_in_b");
    drive_period(1136, 1136);
    check_status("tol_out");
    check("tol_out period direct", period, 2400);
    check("tol_out hit direct", note_hit, 0);

    // Note change A4 -> C5
    drive_period(1136, 1136);
    for (int i = 0; i < 3; i++) begin
      drive_period(956, 956);
      check_status("c5");
    end

    // Glitch inside an A4 stream
    for (int i = 0; i < 3; i++) begin
      drive_period(1136, 1136);
      check_status("pre_glitch");
    end
    drive_period(5, 5);
    drive_period(1131, 1131);
    check_status("glitch");
    for (int i = 0; i < 2; i++) begin
      drive_period(1136, 1136);
      check_status("post_glitch");
    end

    // Reset in the middle of a high phase
    model_rise(cyc);
    tone_in = 1'b1;
    repeat (500) @(negedge clk);
    check("pre_reset note_hit", note_hit, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    tone_in = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Silence after the last rising edge
    for (int i = 0; i < 3; i++) begin
      t_last = cyc;
      drive_period(1136, 1136);
    end
    check_status("pre_silence");
    while (cyc < t_last + TIMEOUT + 2) @(negedge clk);
    check("silence not yet", silence, 0);
    check("hit before silence", note_hit, 1);
    @(negedge clk);
    check("silence asserted", silence, 1);
    check("hit after silence", note_hit, 0);
    model_silence();

    // Randomised note groups; the first two periods also exercise restart after silence
    for (int g = 0; g < 5; g++) begin
      int n, p0, tol;
      n = int'($urandom_range(7, 0));
      p0 = CLK_HZ / hz_tab[n];
      tol = p0 >> TOL_SHIFT;
      for (int k = 0; k < 2; k++) begin
        int p;
        if ($urandom_range(5, 0) == 0) p = p0 + tol + 15 + int'($urandom_range(20, 0));
        else p = p0 - tol / 2 + int'($urandom_range(tol, 0));
        drive_period(p / 2, p - p / 2);
        check_status("rand");
      end
    end

    drive_period(200, 200);
    repeat (30) @(negedge clk);
    check("pending strobes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
